// File: rtl/y86_execute_stage_p.sv
// Pipelined Y86-64 execute stage: valE/ALU, condition evaluation, condition-code register
// and the E->M pipeline register with stall/bubble control and exception-gated CC update.
module y86_execute_stage_p #(
  parameter int DATA_W     = 64,
  parameter int STACK_STEP = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [DATA_W-1:0] E_valA,
  input  logic [DATA_W-1:0] E_valB,
  input  logic [DATA_W-1:0] E_valC,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic              set_cc_en,
  input  logic              stall,
  input  logic              bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_cnd,
  output logic [3:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM,
  output logic [2:0]        cc_out
);
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] S_AOK   = 4'h1;
  localparam logic [3:0] S_INS   = 4'h4;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);

  logic [DATA_W-1:0] sum, diff, alu_res;
  logic              of_add, of_sub, alu_of;
  logic              illegal, cc_we;
  logic [3:0]        stat_c;
  logic [2:0]        new_cc;
  logic              zf, sf, of;

  assign {zf, sf, of} = cc_out;

  assign sum    = E_valB + E_valA;
  assign diff   = E_valB - E_valA;
  assign of_add = (E_valA[DATA_W-1] == E_valB[DATA_W-1]) && (sum[DATA_W-1] != E_valA[DATA_W-1]);
  assign of_sub = (E_valA[DATA_W-1] != E_valB[DATA_W-1]) && (diff[DATA_W-1] != E_valB[DATA_W-1]);

  always_comb begin
    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    alu_res = '0;
    alu_of  = 1'b0;
    case (E_ifun)
      4'h0: begin alu_res = sum;  alu_of = of_add; end
      4'h1: begin alu_res = diff; alu_of = of_sub; end
      4'h2: alu_res = E_valB & E_valA;
      4'h3: alu_res = E_valB ^ E_valA;
      default: ;
    endcase
  end

  assign new_cc = {alu_res == '0, alu_res[DATA_W-1], alu_of};

  assign illegal = ((E_icode == I_OPQ) && (E_ifun > 4'h3)) ||
                   (((E_icode == I_CMOV) || (E_icode == I_JXX)) && (E_ifun > 4'h6));

  // An exception that arrived from decode takes precedence over one raised here.
  assign stat_c = ((E_stat == S_AOK) && illegal) ? S_INS : E_stat;

  always_comb begin
    e_cnd = 1'b0;
    if (((E_icode == I_CMOV) || (E_icode == I_JXX)) && !illegal) begin
      case (E_ifun)
        4'h0:    e_cnd = 1'b1;
        4'h1:    e_cnd = (sf ^ of) | zf;
        4'h2:    e_cnd = sf ^ of;
        4'h3:    e_cnd = zf;
        4'h4:    e_cnd = !zf;
        4'h5:    e_cnd = !(sf ^ of);
        4'h6:    e_cnd = !(sf ^ of) & !zf;
        default: e_cnd = 1'b0;
      endcase
    end
  end

  always_comb begin
    e_valE = '0;
    if (!illegal) begin
      case (E_icode)
        I_CMOV:           e_valE = E_valA;
        I_IRMOV:          e_valE = E_valC;
        I_RMMOV, I_MRMOV: e_valE = E_valB + E_valC;
        I_OPQ:            e_valE = alu_res;
        I_CALL, I_PUSH:   e_valE = E_valB - STEP;
        I_RET, I_POP:     e_valE = E_valB + STEP;
        default:          ;
      endcase
    end
  end

  assign e_dstE = (illegal || ((E_icode == I_CMOV) && !e_cnd)) ? R_NONE : E_dstE;

  assign cc_we = (E_icode == I_OPQ) && !illegal && (E_stat == S_AOK) &&
                 set_cc_en && !stall && !bubble;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_out  <= 3'b100;
      M_stat  <= S_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
    end else begin
      if (cc_we) cc_out <= new_cc;
      if (!stall) begin
        if (bubble) begin
          M_stat  <= S_AOK;
          M_icode <= I_NOP;
          M_cnd   <= 1'b0;
          M_valE  <= '0;
          M_valA  <= '0;
          M_dstE  <= R_NONE;
          M_dstM  <= R_NONE;
        end else begin
          M_stat  <= stat_c;
          M_icode <= E_icode;
          M_cnd   <= e_cnd;
          M_valE  <= e_valE;
          M_valA  <= E_valA;
          M_dstE  <= e_dstE;
          M_dstM  <= E_dstM;
        end
      end
    end
  end
endmodule

// File: tb/tb_y86_execute_stage_p.sv
// Scoreboard bench for y86_execute_stage_p: a 64-bit instance carries most scenarios,
// a 32-bit / step-4 instance covers the parametrised wrap-around case.
module tb_y86_execute_stage_p;
  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [2:0]  cc;
  } m_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] e64;
    logic [31:0] e32;
  } stk_t;

  logic        clk = 1'b0;
  logic        reset, set_cc_en, stall, bubble;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;

  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
  logic        e_cnd, M_cnd;
  logic [2:0]  cc_out;

  logic [31:0] e_valE32, M_valE32, M_valA32;
  logic [3:0]  e_dstE32, M_stat32, M_icode32, M_dstE32, M_dstM32;
  logic        e_cnd32, M_cnd32;
  logic [2:0]  cc_out32;

  m_t   m_act, exp_m, last_m;
  m_t   sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [2:0] cc_exp;

  y86_execute_stage_p #(.DATA_W(64), .STACK_STEP(8)) dut (
    .clk(clk), .reset(reset), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .set_cc_en(set_cc_en), .stall(stall), .bubble(bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .cc_out(cc_out)
  );

  y86_execute_stage_p #(.DATA_W(32), .STACK_STEP(4)) dut32 (
    .clk(clk), .reset(reset), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA[31:0]), .E_valB(E_valB[31:0]), .E_valC(E_valC[31:0]),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .set_cc_en(set_cc_en), .stall(stall), .bubble(bubble),
    .e_valE(e_valE32), .e_dstE(e_dstE32), .e_cnd(e_cnd32),
    .M_stat(M_stat32), .M_icode(M_icode32), .M_cnd(M_cnd32), .M_valE(M_valE32),
    .M_valA(M_valA32), .M_dstE(M_dstE32), .M_dstM(M_dstM32), .cc_out(cc_out32)
  );

  assign m_act = {M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out};

  always #5 clk = ~clk;

  function automatic m_t mk(input logic [3:0] st, input logic [3:0] ic, input logic cn,
                            input logic [63:0] ve, input logic [63:0] va,
                            input logic [3:0] de, input logic [3:0] dm, input logic [2:0] cc);
    return {st, ic, cn, ve, va, de, dm, cc};
  endfunction

  function automatic m_t nop_m(input logic [2:0] cc);
    return mk(4'h1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, cc);
  endfunction

  function automatic logic cond_model(input logic [2:0] cc, input logic [3:0] fn);
    logic z, s, o;
    {z, s, o} = cc;
    case (fn)
      4'h0: return 1'b1;
      4'h1: return (s != o) || z;
      4'h2: return s != o;
      4'h3: return z;
      4'h4: return !z;
      4'h5: return s == o;
      4'h6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    E_stat = st; E_icode = ic; E_ifun = fn;
    E_valA = a;  E_valB = b;   E_valC = c;
    E_dstE = de; E_dstM = dm;
  endtask

  task automatic push(input m_t e);
    sb.push_back(e);
    last_m = e;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'b1; bubble = 1'b1; set_cc_en = 1'b1;
    drive(4'h1, 4'h6, 4'h0, 64'h5, 64'h6, 64'h0, 4'h2, 4'hF);
    cc_exp = 3'b100;
    push(nop_m(cc_exp));
    @(posedge clk); #1;
    exp_m = sb.pop_front();
    checks++;
    if (m_act !== exp_m) begin
      errors++; $display("FAIL reset_state: got %h want %h", m_act, exp_m);
    end
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; bubble = 1'b0;
  endtask

  task automatic test_addq_overflow();
    @(negedge clk);
    drive(4'h1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h2, 4'hF);
    #1;
    checks++;
    if ({e_valE, e_dstE, e_cnd} !== {64'h8000_0000_0000_0000, 4'h2, 1'b0}) begin
      errors++; $display("FAIL addq_fwd: got %h/%h/%b want 8000000000000000/2/0", e_valE, e_dstE, e_cnd);
    end
    cc_exp = 3'b011;
    push(mk(4'h1, 4'h6, 1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 4'hF, cc_exp));
    @(posedge clk); #1;
    exp_m = sb.pop_front();
    checks++;
    if (m_act !== exp_m) begin
      errors++; $display("FAIL addq_M: got %h want %h", m_act, exp_m);
    end
  endtask

  task automatic test_subq_cond();
    logic exp_c [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    drive(4'h1, 4'h6, 4'h1, 64'h25, 64'h25, 64'h0, 4'h3, 4'hF);
    #1;
    checks++;
    if ({e_valE, e_dstE} !== {64'h0, 4'h3}) begin
      errors++; $display("FAIL subq_fwd: got %h/%h want 0/3", e_valE, e_dstE);
    end
    cc_exp = 3'b100;
    push(mk(4'h1, 4'h6, 1'b0, 64'h0, 64'h25, 4'h3, 4'hF, cc_exp));
    @(posedge clk); #1;
    exp_m = sb.pop_front();
    checks++;
    if (m_act !== exp_m) begin
      errors++; $display("FAIL subq_M: got %h want %h", m_act, exp_m);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(4'h1, 4'h7, 4'(i), 64'h40, 64'h0, 64'h1000, 4'hF, 4'hF);
      #1;
      checks++;
      if ({e_valE, e_dstE, e_cnd} !== {64'h0, 4'hF, exp_c[i]}) begin
        errors++; $display("FAIL jxx_fwd ifun=%0d: got %h/%h/%b want 0/f/%b", i, e_valE, e_dstE, e_cnd, exp_c[i]);
      end
      push(mk(4'h1, 4'h7, exp_c[i], 64'h0, 64'h40, 4'hF, 4'hF, cc_exp));
      @(posedge clk); #1;
      exp_m = sb.pop_front();
      checks++;
      if (m_act !== exp_m) begin
        errors++; $display("FAIL jxx_M ifun=%0d: got %h want %h", i, m_act, exp_m);
      end
    end
  endtask

  task automatic test_cmov();
    // cc=000 via 1+1, then cmovl must squash its destination
    @(negedge clk);
    drive(4'h1, 4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h6, 4'hF);
    cc_exp = 3'b000;
    push(mk(4'h1, 4'h6, 1'b0, 64'h2, 64'h1, 4'h6, 4'hF, cc_exp));
    @(posedge clk); #1;
    exp_m = sb.pop_front();
    checks++;
    if (m_act !== exp_m) begin
      errors++; $display("FAIL cmov_setup1_M: got %h want %h", m_act, exp_m);
    end
    @(negedge clk);
    drive(4'h1, 4'h2, 4'h2, 64'hABC, 64'h0, 64'h0, 4'h3, 4'hF);
    #1;
    checks++;
    if ({e_valE, e_dstE, e_cnd} !== {64'hABC, 4'hF, 1'b0}) begin
      errors++; $display("FAIL cmovl_false_fwd: got %h/%h/%b want abc/f/0", e_valE, e_dstE, e_cnd);
    end
    push(mk(4'h1, 4'h2, 1'b0, 64'hABC, 64'hABC, 4'hF, 4'hF, cc_exp));
    @(posedge clk); #1;
    exp_m = sb.pop_front();
    checks++;
    if (m_act !== exp_m) begin
      errors++; $display("FAIL cmovl_false_M: got %h want %h", m_act, exp_m);
    end
    // cc=010 via 1-2, then cmovl moves
    @(negedge clk);
    drive(4'h1, 4'h6, 4'h1, 64'h2, 64'h1, 64'h0, 4'h6, 4'hF);
    cc_exp = 3'b010;
    push(mk(4'h1, 4'h6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 4'h6, 4'hF, cc_exp));
    @(posedge clk); #1;
    exp_m = sb.pop_front();
    checks++;
    if (m_act !== exp_m) begin
      errors++; $display("FAIL cmov_setup2_M: got %h want %h", m_act, exp_m);
    end
    @(negedge clk);
    drive(4'h1, 4'h2, 4'h2, 64'hABC, 64'h0, 64'h0, 4'h3, 4'hF);
    #1;
    checks++;
    if ({e_valE, e_dstE, e_cnd} !== {64'hABC, 4'h3, 1'b1}) begin
      errors++; $display("FAIL cmovl_true_fwd: got %h/%h/%b want abc/3/1", e_valE, e_dstE, e_cnd);
    end
    push(mk(4'h1, 4'h2, 1'b1, 64'hABC, 64'hABC, 4'h3, 4'hF, cc_exp));
    @(posedge clk); #1;
    exp_m = sb.pop_front();
    checks++;
    if (m_act !== exp_m) begin
      errors++; $display("FAIL cmovl_true_M: got %h want %h", m_act, exp_m);
    end
  endtask

  task automatic test_stack_and_mem();
    stk_t tbl [9] = '{
      '{4'hA, 64'h100,                 64'h0,    64'hF8,                  32'hFC},
      '{4'hB, 64'h0,                   64'h0,    64'h8,                   32'h4},
      '{4'hA, 64'h0,                   64'h0,    64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFFC},
      '{4'h8, 64'h200,                 64'h0,    64'h1F8,                 32'h1FC},
      '{4'h9, 64'h1F8,                 64'h0,    64'h200,                 32'h1FC},
      '{4'h3, 64'h55,                  64'h1234, 64'h1234,                32'h1234},
      '{4'h4, 64'h10,                  64'h8,    64'h18,                  32'h18},
      '{4'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,    64'h1,                   32'h1},
      '{4'h0, 64'h5,                   64'h5,    64'h0,                   32'h0}
    };
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(4'h1, tbl[i].icode, 4'h0, 64'h55, tbl[i].b, tbl[i].c, 4'h4, 4'hF);
      #1;
      checks++;
      if ({e_valE, e_dstE, e_cnd} !== {tbl[i].e64, 4'h4, 1'b0}) begin
        errors++; $display("FAIL valE64_fwd icode=%h: got %h/%h/%b want %h/4/0", tbl[i].icode, e_valE, e_dstE, e_cnd, tbl[i].e64);
      end
      checks++;
      if (e_valE32 !== tbl[i].e32) begin
        errors++; $display("FAIL valE32_fwd icode=%h: got %h want %h", tbl[i].icode, e_valE32, tbl[i].e32);
      end
      push(mk(4'h1, tbl[i].icode, 1'b0, tbl[i].e64, 64'h55, 4'h4, 4'hF, cc_exp));
      @(posedge clk); #1;
      exp_m = sb.pop_front();
      checks++;
      if (m_act !== exp_m) begin
        errors++; $display("FAIL valE64_M icode=%h: got %h want %h", tbl[i].icode, m_act, exp_m);
      end
      checks++;
      if (M_valE32 !== tbl[i].e32) begin
        errors++; $display("FAIL valE32_M icode=%h: got %h want %h", tbl[i].icode, M_valE32, tbl[i].e32);
      end
    end
  endtask

  task automatic test_stall_bubble();
    // phases: stall, bubble, stall+bubble, set_cc_en=0, non-AOK stat
    logic [3:0] st;
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      stall     = (p == 0) || (p == 2);
      bubble    = (p == 1) || (p == 2);
      set_cc_en = (p != 3);
      st        = (p == 4) ? 4'h3 : 4'h1;
      drive(st, 4'h6, 4'h0, 64'h3, 64'h4, 64'h0, 4'h5, 4'hF);
      #1;
      checks++;
      if ({e_valE, e_dstE} !== {64'h7, 4'h5}) begin
        errors++; $display("FAIL ctl_fwd phase=%0d: got %h/%h want 7/5", p, e_valE, e_dstE);
      end
      if (stall)       push(last_m);
      else if (bubble) push(nop_m(cc_exp));
      else             push(mk(st, 4'h6, 1'b0, 64'h7, 64'h3, 4'h5, 4'hF, cc_exp));
      @(posedge clk); #1;
      exp_m = sb.pop_front();
      checks++;
      if (m_act !== exp_m) begin
        errors++; $display("FAIL ctl_M phase=%0d: got %h want %h", p, m_act, exp_m);
      end
    end
    @(negedge clk);
    stall = 1'b0; bubble = 1'b0; set_cc_en = 1'b1;
  endtask

  task automatic test_illegal_and_reset();
    logic [3:0] ics [3] = '{4'h6, 4'h7, 4'h2};
    logic [3:0] fns [3] = '{4'h7, 4'h9, 4'h7};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(4'h1, ics[i], fns[i], 64'h5, 64'h5, 64'h9, 4'h2, 4'hF);
      #1;
      checks++;
      if ({e_valE, e_dstE, e_cnd} !== {64'h0, 4'hF, 1'b0}) begin
        errors++; $display("FAIL illegal_fwd icode=%h: got %h/%h/%b want 0/f/0", ics[i], e_valE, e_dstE, e_cnd);
      end
      push(mk(4'h4, ics[i], 1'b0, 64'h0, 64'h5, 4'hF, 4'hF, cc_exp));
      @(posedge clk); #1;
      exp_m = sb.pop_front();
      checks++;
      if (m_act !== exp_m) begin
        errors++; $display("FAIL illegal_M icode=%h: got %h want %h", ics[i], m_act, exp_m);
      end
    end
    @(negedge clk);
    drive(4'h1, 4'h6, 4'h0, 64'h10, 64'h20, 64'h0, 4'h7, 4'hF);
    cc_exp = 3'b000;
    push(mk(4'h1, 4'h6, 1'b0, 64'h30, 64'h10, 4'h7, 4'hF, cc_exp));
    @(posedge clk); #1;
    exp_m = sb.pop_front();
    checks++;
    if (m_act !== exp_m) begin
      errors++; $display("FAIL pre_reset_M: got %h want %h", m_act, exp_m);
    end
    @(negedge clk);
    reset = 1'b1; stall = 1'b1;
    drive(4'h1, 4'h6, 4'h1, 64'h1, 64'h9, 64'h0, 4'h7, 4'hF);
    cc_exp = 3'b100;
    push(nop_m(cc_exp));
    @(posedge clk); #1;
    exp_m = sb.pop_front();
    checks++;
    if (m_act !== exp_m) begin
      errors++; $display("FAIL midstream_reset_M: got %h want %h", m_act, exp_m);
    end
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
  endtask

  task automatic test_random_alu();
    logic [63:0] a, b, r;
    logic [3:0]  fn, jf, de;
    logic        o, c;
    for (int i = 0; i < 24; i++) begin
      fn = 4'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a[63] = ~a[63];
      de = 4'($urandom_range(0, 14));
      case (fn)
        4'h0: begin r = b + a; o = (a[63] == b[63]) && (r[63] != a[63]); end
        4'h1: begin r = b - a; o = (a[63] != b[63]) && (r[63] != b[63]); end
        4'h2: begin r = b & a; o = 1'b0; end
        default: begin r = b ^ a; o = 1'b0; end
      endcase
      @(negedge clk);
      drive(4'h1, 4'h6, fn, a, b, 64'h0, de, 4'hF);
      cc_exp = {r == 64'h0, r[63], o};
      push(mk(4'h1, 4'h6, 1'b0, r, a, de, 4'hF, cc_exp));
      @(posedge clk); #1;
      exp_m = sb.pop_front();
      checks++;
      if (m_act !== exp_m) begin
        errors++; $display("FAIL rand_alu_M i=%0d ifun=%0d: got %h want %h", i, fn, m_act, exp_m);
      end
      jf = 4'($urandom_range(0, 6));
      c  = cond_model(cc_exp, jf);
      @(negedge clk);
      drive(4'h1, 4'h7, jf, 64'h77, 64'h0, 64'h400, 4'hF, 4'hF);
      push(mk(4'h1, 4'h7, c, 64'h0, 64'h77, 4'hF, 4'hF, cc_exp));
      @(posedge clk); #1;
      exp_m = sb.pop_front();
      checks++;
      if (m_act !== exp_m) begin
        errors++; $display("FAIL rand_jxx_M i=%0d ifun=%0d: got %h want %h", i, jf, m_act, exp_m);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; bubble = 1'b0; set_cc_en = 1'b1;
    drive(4'h1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    last_m = nop_m(3'b100);
    cc_exp = 3'b100;
    test_reset();
    test_addq_overflow();
    test_subq_cond();
    test_cmov();
    test_stack_and_mem();
    test_stall_bubble();
    test_illegal_and_reset();
    test_random_alu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
